// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the round-robin search used by fifo_wr_arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of valid_vec at or after ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                       input logic [3:0] ptr,
                                       input int n);
    rr_pick_t res;
    int       pos;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        pos = (int'(ptr) + k) % n;
        if (valid_vec[pos[3:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[3:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Combinational round-robin pick for fifo_wr_arbiter; holds no state.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid), 4'(ptr), NUM_REQ);
    found = pick.found;
    idx   = ID_W'(pick.idx);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one FIFO write port; words tagged {ID, payload}.
// Optional per-requester grant and full-stall counters under FIFO_WR_ARBITER_STATS_EN.
//   state  | meaning
//   IDLE   | round-robin among valid requesters starting at rr_ptr
//   LOCKED | mid-packet; only lock_id may transfer until its last word
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DWIDTH    = 16,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int PAYLOAD_W = DWIDTH - ID_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fifo_wr_en,
  output logic [DWIDTH-1:0]              fifo_din,
  input  logic                           fifo_full
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]      grant_cnt,
  output logic [STAT_W-1:0]              full_stall_cnt
`endif
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   rr_idx, sel_id;
  logic              rr_found, stage_free, xfer;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign stage_free = !out_valid_q || !fifo_full;
  // Gated by rst_n so a word caught in the stage during reset is dropped, never written.
  assign fifo_wr_en = rst_n && out_valid_q && !fifo_full;
  assign fifo_din   = out_data_q;
  assign xfer       = |(req_valid & req_ready);

  always_comb begin
    req_ready = '0;
    sel_id    = (state_q == LOCKED) ? lock_id_q : rr_idx;
    if (rst_n && stage_free) begin
      if (state_q == LOCKED) req_ready[lock_id_q] = 1'b1;
      else if (rr_found)     req_ready[rr_idx]    = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = {sel_id, req_data[int'(sel_id)*PAYLOAD_W +: PAYLOAD_W]};
      if (req_last[sel_id]) begin
        state_d  = IDLE;
        rr_ptr_d = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
      end else begin
        state_d   = LOCKED;
        lock_id_d = sel_id;
      end
    end else if (fifo_wr_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [STAT_W-1:0]              full_stall_q, full_stall_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (req_valid[i] && req_ready[i] && grant_cnt_q[i] != '1)
        grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
    end
    full_stall_d = full_stall_q;
    if (out_valid_q && fifo_full && full_stall_q != '1)
      full_stall_d = full_stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt_q  <= '0;
      full_stall_q <= '0;
    end else begin
      grant_cnt_q  <= grant_cnt_d;
      full_stall_q <= full_stall_d;
    end
  end

  assign grant_cnt      = grant_cnt_q;
  assign full_stall_cnt = full_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: reference model predicts grants and FIFO words.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int PW    = 14;
  localparam int DEPTH = 1023;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N*PW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic          fifo_full = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     full_stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DWIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .grant_cnt      (grant_cnt),
    .full_stall_cnt (full_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // producer packet queues, expected FIFO words, and the reference model state
  logic [PW-1:0] pq_data [N][$];
  logic          pq_last [N][$];
  logic [N-1:0]  pending = '0;
  logic [DW-1:0] sb [$];
  bit m_ov = 0, m_locked = 0, rst_prev = 0;
  int m_lock = 0, m_ptr = 0;
  int grants [N];
  int stall = 0;

  bit rst_req = 0, force_valid = 0, drain = 0;
  int gen_mode = 0, full_mode = 0, fcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      pq_data[r].push_back(base < 0 ? PW'($urandom) : PW'(base + k));
      pq_last[r].push_back(k == len - 1);
    end
  endtask

  task automatic cycle();
    logic [N-1:0] exp_rdy;
    bit sf, exp_wr;
    int g, pos;
    @(negedge clk);
    rst_n = rst_req;
    if (drain && fcnt > 0 && $urandom_range(0, 1) == 1) fcnt--;
    case (full_mode)
      0: fifo_full = 1'b0;
      1: fifo_full = ($urandom_range(0, 3) == 0);
      2: fifo_full = 1'b1;
      default: fifo_full = (fcnt >= DEPTH);
    endcase
    for (int i = 0; i < N; i++) begin
      if (gen_mode != 0 && pq_data[i].size() == 0)
        push_pkt(i, gen_mode == 1 ? 1 : int'($urandom_range(1, 4)), -1);
      if (!pending[i] && pq_data[i].size() > 0 && (force_valid || $urandom_range(0, 3) != 0))
        pending[i] = 1'b1;
      req_valid[i] = pending[i];
      req_data[i*PW +: PW] = pending[i] ? pq_data[i][0] : PW'($urandom);
      req_last[i] = pending[i] ? pq_last[i][0] : 1'($urandom_range(0, 1));
    end
    #1;
    exp_rdy = '0;
    sf = !m_ov || !fifo_full;
    if (rst_n && sf) begin
      if (m_locked) exp_rdy[m_lock] = 1'b1;
      else begin
        for (int k = N - 1; k >= 0; k--) begin
          pos = (m_ptr + k) % N;
          if (req_valid[pos]) exp_rdy = N'(1) << pos;
        end
      end
    end
    exp_wr = rst_n && m_ov && !fifo_full;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    if (!rst_n && rst_prev) check("reset_din", 32'(fifo_din), 32'h0);
    if (!rst_n) begin
      m_ov = 0; m_locked = 0; m_ptr = 0; stall = 0;
      sb.delete();
      pending = '0;
      for (int i = 0; i < N; i++) begin
        pq_data[i].delete(); pq_last[i].delete(); grants[i] = 0;
      end
    end else begin
      if (m_ov && fifo_full) stall++;
      g = -1;
      for (int i = 0; i < N; i++) if (req_valid[i] && exp_rdy[i]) g = i;
      if (g >= 0) begin
        sb.push_back({2'(g), pq_data[g][0]});
        m_ov = 1;
        grants[g]++;
        if (pq_last[g][0]) begin m_locked = 0; m_ptr = (g + 1) % N; end
        else begin m_locked = 1; m_lock = g; end
        void'(pq_data[g].pop_front());
        void'(pq_last[g].pop_front());
        pending[g] = 1'b0;
      end else if (exp_wr) m_ov = 0;
    end
    rst_prev = !rst_n;
  endtask

  // monitor: every FIFO write must match the oldest expected word
  initial begin
    logic [DW-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (fifo_wr_en === 1'b1) begin
        check("wr_while_full", 32'(fifo_full), 32'h0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%h required=none t=%0t", fifo_din, $time);
        end else begin
          exp = sb.pop_front();
          check("fifo_din", 32'(fifo_din), 32'(exp));
        end
        fcnt++;
      end
    end
  end

  initial begin
    int k;
    // reset held with every requester valid
    rst_req = 0; gen_mode = 1; force_valid = 1;
    repeat (3) cycle();
    // continuous single-word packets
    rst_req = 1;
    repeat (40) cycle();
    // 5-word locked packet on requester 2, stalled by full mid-packet
    gen_mode = 0; rst_req = 0; cycle(); rst_req = 1;
    push_pkt(0, 1, 'h10); push_pkt(1, 1, 'h11); push_pkt(2, 5, 'h100); push_pkt(3, 1, 'h13);
    repeat (4) cycle();
    full_mode = 2;
    repeat (4) begin
      cycle();
      check("full_hold_din", 32'(fifo_din), 32'h8101);
      check("full_no_ready", 32'(req_ready), 32'h0);
    end
    full_mode = 0;
    repeat (8) cycle();
    // randomized traffic, random full, occasional reset
    gen_mode = 2; force_valid = 0; full_mode = 1;
    repeat (2000) begin
      rst_req = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_req = 1;
    // fill a 1023-deep FIFO model through the arbiter, then drain
    full_mode = 3; fcnt = 0; drain = 0;
    k = 0;
    while (fcnt < DEPTH && k < 3000) begin cycle(); k++; end
    repeat (10) cycle();
    check("fill_count", 32'(fcnt), 32'(DEPTH));
    drain = 1; gen_mode = 0;
    repeat (300) cycle();
    drain = 0; full_mode = 0;
    // reset while locked on requester 1
    rst_req = 0; force_valid = 1; cycle(); rst_req = 1;
    push_pkt(1, 8, 'h200);
    k = 0;
    while (!(m_locked && m_lock == 1) && k < 10) begin cycle(); k++; end
    if (!(m_locked && m_lock == 1)) begin
      checks++; errors++;
      $display("FAIL lock_timeout actual=unlocked required=locked_on_1");
    end
    cycle();
    rst_req = 0; cycle(); cycle(); rst_req = 1;
    push_pkt(2, 1, 'h300); push_pkt(3, 1, 'h301);
    cycle();
    check("post_reset_grant", 32'(req_ready), 32'h4);
    // let everything drain
    k = 0;
    while ((sb.size() != 0 || pending != 0) && k < 200) begin cycle(); k++; end
    repeat (3) cycle();
    check("sb_empty", 32'(sb.size()), 32'h0);
`ifdef FIFO_WR_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) check("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(grants[i]));
    check("full_stall_cnt", 32'(full_stall_cnt), 32'(stall));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
